auth_request_arbiter: RTL and testbench
=======================================

Name: auth_request_arbiter

Overview:
- Shares the single authentication driver between the PD and DEBUG requester channels.
- Watches the two 8-bit pending-request registers and grants the driver to one channel at a time, round-robin on ties.
- Sequences each transaction: start pulse, wait for done or timeout, then a one-cycle erase pulse back to the served channel.
- Sits between the PD/DEBUG front end and authentication_driver.

Parameters:
- TIMEOUT_CYCLES, 1000: WAIT cycles before the transaction is aborted; legal range 2..65535.
- CNT_W, 16: width of the internal timeout counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- pending_auth_request_PD  input  8  PD request code; nonzero means pending.
- pending_auth_request_DEBUG  input  8  DEBUG request code; nonzero means pending.
- drv_done  input  1  driver finished the current request; one-cycle pulse.
- pending_auth_request_PD_erase  output  1  one-cycle pulse that clears the PD pending register.
- pending_auth_request_DEBUG_erase  output  1  one-cycle pulse that clears the DEBUG pending register.
- drv_start  output  1  one-cycle pulse that starts the driver.
- drv_req_code  output  8  latched request code of the granted channel.
- drv_channel  output  1  granted channel: 0 = PD, 1 = DEBUG.
- grant_PD  output  1  PD owns the driver.
- grant_DEBUG  output  1  DEBUG owns the driver.
- busy  output  1  high whenever state is not IDLE.
- timeout_err  output  1  one-cycle pulse when a transaction times out.
- timeout_count  output  8  saturating count of timeouts.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state = IDLE; every output = 0; last_served = DEBUG, so PD wins the first tie; counter = 0; mask = none.
  - Reset mid-transaction aborts immediately with no erase pulse; timeout_count clears.
- States: IDLE, WAIT, RELEASE.
- IDLE:
  - A channel is eligible when its pending value is nonzero and it is not masked.
  - Only PD eligible → grant PD. Only DEBUG eligible → grant DEBUG. Both eligible → grant the channel != last_served.
  - On a grant, at the next edge: state = WAIT, drv_start = 1, drv_req_code = that channel's pending value, drv_channel set, grant_x = 1, counter = 0.
  - Latency is one cycle from pending visible in IDLE to drv_start high.
  - mask clears after the first IDLE cycle.
- WAIT:
  - drv_start is high only in the first WAIT cycle; drv_done is ignored in that cycle.
  - drv_req_code and drv_channel are stable for the whole of WAIT and RELEASE; changes on the pending inputs are ignored.
  - Counter increments every WAIT cycle.
  - drv_done == 1 (second WAIT cycle or later) → RELEASE.
  - Otherwise, counter == TIMEOUT_CYCLES-1 → RELEASE, timeout_err = 1 for that RELEASE cycle, timeout_count += 1, saturating at 255.
  - drv_done and timeout in the same cycle: done wins, no timeout_err.
- RELEASE (exactly one cycle):
  - Erase pulse on the granted channel's erase output.
  - last_served = granted channel; mask = granted channel.
  - Next state IDLE; grant_x drops on leaving RELEASE.
  - The erase fires on timeout too, so a stale request is dropped.
- Masking: the served channel is ignored for the first IDLE cycle after RELEASE. This covers requesters whose pending register clears one cycle after the erase.
- Output rules:
  - grant_PD and grant_DEBUG are never both high.
  - busy = (state != IDLE).
  - drv_done outside WAIT is ignored.
  - drv_req_code holds its last value in IDLE.
- Throughput: minimum transaction is 4 cycles (grant edge, start, done, release).
- Counter width: CNT_W must hold TIMEOUT_CYCLES-1; the counter never wraps because it is compared for equality.

Test Plan:
- Reset: reset=0 for 3 cycles with both pending = 8'h11 → all outputs 0, state IDLE; after release, PD is granted first with drv_req_code = 8'h11, drv_channel = 0.
- Single PD request: PD = 8'h05; drv_done pulsed 3 cycles after drv_start → one drv_start, grant_PD high for 5 cycles, one PD_erase pulse in the cycle after done, busy low after.
- Both pending, PD = 8'h01, DEBUG = 8'h02, done returned each time → grants alternate PD, DEBUG, PD, DEBUG over 4 transactions; requests re-assert after each erase.
- Timeout with TIMEOUT_CYCLES = 8 and no drv_done → timeout_err pulse exactly 8 cycles after drv_start, DEBUG_erase pulse in the same cycle, timeout_count = 1; 300 timeouts → timeout_count = 255.
- Done/timeout collision: drv_done coincides with counter = TIMEOUT_CYCLES-1 → no timeout_err, timeout_count unchanged.
- Reset mid-WAIT and stray done: reset=0 during WAIT → no erase pulse and grants drop next edge; drv_done pulsed in IDLE or in the drv_start cycle → no state change.

Source files
------------

// File: rtl/auth_request_arbiter.sv
// -----------------------------------------------------------------------------
// auth_request_arbiter
//
// Shares one authentication driver between the PD and DEBUG requester
// channels. A channel requests service by holding a nonzero code in its
// pending register. The arbiter grants one channel at a time. When both
// channels request in the same cycle, the one not served last wins.
//
// Each transaction runs as follows:
//   IDLE    -> pick a channel, latch its code and its channel number
//   WAIT    -> drv_start pulses in the first cycle; the arbiter then waits for
//              drv_done, or aborts after TIMEOUT_CYCLES WAIT cycles
//   RELEASE -> a one-cycle erase pulse goes back to the served channel
//
// After RELEASE the served channel is masked for one IDLE cycle. This lets a
// requester whose pending register clears one cycle late avoid being granted
// again.
//
// Ports
//   clk                              system clock, rising edge
//   reset                            synchronous, active-low reset
//   pending_auth_request_PD    [7:0] PD request code (nonzero = pending)
//   pending_auth_request_DEBUG [7:0] DEBUG request code (nonzero = pending)
//   drv_done                         driver finished (one-cycle pulse)
//   pending_auth_request_PD_erase    clears the PD pending register
//   pending_auth_request_DEBUG_erase clears the DEBUG pending register
//   drv_start                        starts the driver (one-cycle pulse)
//   drv_req_code               [7:0] latched code of the granted channel
//   drv_channel                      granted channel: 0 = PD, 1 = DEBUG
//   grant_PD / grant_DEBUG           channel currently owns the driver
//   busy                             state is not IDLE
//   timeout_err                      one-cycle pulse on a timed-out transaction
//   timeout_count              [7:0] saturating count of timeouts
//
// TIMEOUT_CYCLES must be in the range 2..65535. CNT_W must be wide enough to
// hold TIMEOUT_CYCLES-1.
// -----------------------------------------------------------------------------
module auth_request_arbiter #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pending_auth_request_PD,
    input  logic [7:0] pending_auth_request_DEBUG,
    input  logic       drv_done,
    output logic       pending_auth_request_PD_erase,
    output logic       pending_auth_request_DEBUG_erase,
    output logic       drv_start,
    output logic [7:0] drv_req_code,
    output logic       drv_channel,
    output logic       grant_PD,
    output logic       grant_DEBUG,
    output logic       busy,
    output logic       timeout_err,
    output logic [7:0] timeout_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [7:0]       code_reg, code_next;
    logic             chan_reg, chan_next;
    logic             last_reg, last_next;
    logic [1:0]       mask_reg, mask_next;
    logic             timeout_err_reg, timeout_err_next;
    logic [7:0]       tcount_reg, tcount_next;

    // Per-channel view: index 0 = PD, index 1 = DEBUG.
    logic [7:0] pend [2];
    logic [1:0] elig;
    logic [1:0] grant_vec;
    logic [1:0] erase_vec;
    logic       pick_debug;

    assign pend[0] = pending_auth_request_PD;
    assign pend[1] = pending_auth_request_DEBUG;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            assign elig[gi]      = (|pend[gi]) && !mask_reg[gi];
            assign grant_vec[gi] = (state_reg != IDLE) && (chan_reg == 1'(gi));
            assign erase_vec[gi] = (state_reg == RELEASE) && (chan_reg == 1'(gi));
        end
    endgenerate

    // DEBUG wins if it is the only eligible channel, or if both channels are
    // eligible and PD was served last.
    assign pick_debug = elig[1] && (!elig[0] || (last_reg == 1'b0));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            code_reg        <= '0;
            chan_reg        <= 1'b0;
            last_reg        <= 1'b1;      // DEBUG, so PD wins the first tie
            mask_reg        <= '0;
            timeout_err_reg <= 1'b0;
            tcount_reg      <= '0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            code_reg        <= code_next;
            chan_reg        <= chan_next;
            last_reg        <= last_next;
            mask_reg        <= mask_next;
            timeout_err_reg <= timeout_err_next;
            tcount_reg      <= tcount_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        code_next        = code_reg;
        chan_next        = chan_reg;
        last_next        = last_reg;
        mask_next        = mask_reg;
        timeout_err_next = 1'b0;
        tcount_next      = tcount_reg;

        case (state_reg)
            IDLE: begin
                // The mask only lasts for the first IDLE cycle after RELEASE.
                mask_next = '0;
                if (|elig) begin
                    state_next = WAIT;
                    chan_next  = pick_debug;
                    code_next  = pick_debug ? pend[1] : pend[0];
                    cnt_next   = '0;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg + CNT_W'(1);
                // cnt_reg == 0 marks the drv_start cycle. A done in that cycle
                // cannot belong to this transaction. Done has priority over the
                // timeout when both happen in the same cycle.
                if (drv_done && (cnt_reg != '0)) begin
                    state_next = RELEASE;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next       = RELEASE;
                    timeout_err_next = 1'b1;
                    if (tcount_reg != 8'hFF) begin
                        tcount_next = tcount_reg + 8'd1;
                    end
                end
            end
            RELEASE: begin
                state_next          = IDLE;
                last_next           = chan_reg;
                mask_next           = '0;
                mask_next[chan_reg] = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Every output is decoded from registered state, so none of them depend
    // combinationally on the inputs.
    assign drv_start                        = (state_reg == WAIT) && (cnt_reg == '0);
    assign drv_req_code                     = code_reg;
    assign drv_channel                      = chan_reg;
    assign grant_PD                         = grant_vec[0];
    assign grant_DEBUG                      = grant_vec[1];
    assign pending_auth_request_PD_erase    = erase_vec[0];
    assign pending_auth_request_DEBUG_erase = erase_vec[1];
    assign busy                             = (state_reg != IDLE);
    assign timeout_err                      = timeout_err_reg;
    assign timeout_count                    = tcount_reg;

endmodule

// File: tb/tb_auth_request_arbiter.sv
// -----------------------------------------------------------------------------
// tb_auth_request_arbiter
//
// The stimulus process queues the expected start and release events for each
// transaction. The monitor process compares them against the DUT as the DUT
// produces drv_start and erase pulses. Outputs are sampled on the falling
// edge. Inputs also change on the falling edge, so each value is stable before
// the next rising edge.
// -----------------------------------------------------------------------------
module tb_auth_request_arbiter;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pd, dbg;
    logic       drv_done;
    logic       pd_erase, dbg_erase, drv_start, drv_channel;
    logic       grant_PD, grant_DEBUG, busy, timeout_err;
    logic [7:0] drv_req_code, timeout_count;

    always #5 clk = ~clk;

    auth_request_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .clk                              (clk),
        .reset                            (reset),
        .pending_auth_request_PD          (pd),
        .pending_auth_request_DEBUG       (dbg),
        .drv_done                         (drv_done),
        .pending_auth_request_PD_erase    (pd_erase),
        .pending_auth_request_DEBUG_erase (dbg_erase),
        .drv_start                        (drv_start),
        .drv_req_code                     (drv_req_code),
        .drv_channel                      (drv_channel),
        .grant_PD                         (grant_PD),
        .grant_DEBUG                      (grant_DEBUG),
        .busy                             (busy),
        .timeout_err                      (timeout_err),
        .timeout_count                    (timeout_count)
    );

    typedef struct packed {
        logic       ch;
        logic [7:0] code;
    } start_t;

    typedef struct packed {
        logic       ch;
        logic       to;
        logic [7:0] cnt;
        logic [7:0] delay;   // cycles from the drv_start cycle to the erase cycle
    } rel_t;

    start_t start_q[$];
    rel_t   rel_q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     start_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents an event.
    initial begin : monitor
        start_t s;
        rel_t   r;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                check("grant_exclusive", {31'd0, grant_PD & grant_DEBUG}, 32'd0);
            end
            if (drv_start) begin
                start_cyc = cyc;
                if (start_q.size() == 0) begin
                    check("unexpected_start", 32'd1, 32'd0);
                end else begin
                    s = start_q.pop_front();
                    check("start_fields",
                          {20'd0, drv_channel, drv_req_code, grant_PD, grant_DEBUG, busy},
                          {20'd0, s.ch, s.code, ~s.ch, s.ch, 1'b1});
                end
            end
            if (pd_erase || dbg_erase) begin
                if (rel_q.size() == 0) begin
                    check("unexpected_erase", 32'd1, 32'd0);
                end else begin
                    r = rel_q.pop_front();
                    check("release_fields",
                          {19'd0, pd_erase, dbg_erase, timeout_err, grant_PD, grant_DEBUG, timeout_count},
                          {19'd0, ~r.ch, r.ch, r.to, ~r.ch, r.ch, r.cnt});
                    check("release_delay", 32'(cyc - start_cyc), {24'd0, r.delay});
                end
            end else if (timeout_err) begin
                check("stray_timeout_err", 32'd1, 32'd0);
            end
        end
    end

    // Waits on falling edges until drv_start (want_erase=0) or an erase pulse
    // (want_erase=1) is seen, up to the given number of cycles.
    task automatic await_sig(input bit want_erase, input int limit, input string name);
        int n = 0;
        forever begin
            @(negedge clk);
            if (want_erase ? (pd_erase || dbg_erase) : drv_start) break;
            n++;
            if (n >= limit) begin
                checks++;
                errors++;
                $display("FAIL %s actual no event required event within %0d cycles", name, limit);
                break;
            end
        end
    endtask

    // One transaction on channel ch. done_after = 0 means drv_done is never
    // returned, so the transaction times out. stray also pulses drv_done in the
    // drv_start cycle, where it must be ignored.
    task automatic txn(input logic ch, input logic [7:0] code, input int done_after,
                       input bit stray, input logic [7:0] exp_cnt, input bit reassert);
        start_q.push_back('{ch: ch, code: code});
        rel_q.push_back('{ch: ch, to: (done_after == 0), cnt: exp_cnt,
                          delay: (done_after == 0) ? 8'(TO) : 8'(done_after + 1)});
        await_sig(1'b0, 20, "start_wait");
        if (done_after > 0) begin
            drv_done = stray;
            for (int k = 1; k <= done_after; k++) begin
                @(negedge clk);
                drv_done = (k == done_after);
            end
        end
        await_sig(1'b1, TO + 6, "erase_wait");
        drv_done = 1'b0;
        if (ch) dbg = 8'h00; else pd = 8'h00;
        if (reassert) begin
            @(negedge clk);
            if (ch) dbg = code; else pd = code;
        end
    endtask

    initial begin : stimulus
        reset    = 1'b0;
        pd       = 8'h11;
        dbg      = 8'h11;
        drv_done = 1'b0;

        // Reset with both channels pending: every output stays low.
        repeat (3) @(negedge clk);
        check("reset_ctrl",
              {23'd0, drv_start, grant_PD, grant_DEBUG, busy, pd_erase, dbg_erase, timeout_err, drv_channel},
              32'd0);
        check("reset_code", {24'd0, drv_req_code}, 32'd0);
        check("reset_tcount", {24'd0, timeout_count}, 32'd0);

        // First tie goes to PD; minimum-length transaction; then DEBUG.
        reset = 1'b1;
        txn(1'b0, 8'h11, 1, 1'b0, 8'd0, 1'b0);
        txn(1'b1, 8'h11, 2, 1'b0, 8'd0, 1'b0);

        // Single PD request, done three cycles after start.
        pd = 8'h05;
        txn(1'b0, 8'h05, 3, 1'b0, 8'd0, 1'b0);
        @(negedge clk);
        check("pd_after_release", {30'd0, grant_PD, busy}, 32'd0);

        // drv_done while idle has no effect.
        drv_done = 1'b1;
        repeat (2) @(negedge clk);
        drv_done = 1'b0;
        check("idle_stray_done", {31'd0, busy}, 32'd0);

        // Round robin with both requesters continually re-asserting.
        reset = 1'b0;
        pd    = 8'h01;
        dbg   = 8'h02;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        txn(1'b0, 8'h01, 1, 1'b0, 8'd0, 1'b1);
        txn(1'b1, 8'h02, 2, 1'b0, 8'd0, 1'b1);
        txn(1'b0, 8'h01, 2, 1'b1, 8'd0, 1'b1);
        txn(1'b1, 8'h02, 1, 1'b0, 8'd0, 1'b0);
        pd = 8'h00;

        // Timeout on DEBUG.
        dbg = 8'h3C;
        txn(1'b1, 8'h3C, 0, 1'b0, 8'd1, 1'b0);

        // Done in the last WAIT cycle takes priority over the timeout.
        dbg = 8'h3D;
        txn(1'b1, 8'h3D, TO - 1, 1'b0, 8'd1, 1'b0);

        // 300 more timeouts: the count saturates at 255.
        for (int i = 0; i < 300; i++) begin
            pd = 8'hA5;
            txn(1'b0, 8'hA5, 0, 1'b0, (i + 2 > 255) ? 8'd255 : 8'(i + 2), 1'b0);
        end

        // Reset during WAIT: no erase; grant and count clear at the next edge.
        pd = 8'h77;
        start_q.push_back('{ch: 1'b0, code: 8'h77});
        await_sig(1'b0, 20, "start_mid_wait");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_reset_ctrl",
              {26'd0, drv_start, grant_PD, grant_DEBUG, busy, pd_erase, dbg_erase}, 32'd0);
        check("mid_reset_tcount", {24'd0, timeout_count}, 32'd0);
        pd = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_idle", {31'd0, busy}, 32'd0);

        check("start_q_drained", 32'(start_q.size()), 32'd0);
        check("rel_q_drained", 32'(rel_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual still running required finished");
        $fatal(1, "watchdog expired");
    end

endmodule
